// File: rtl/eca_engine.sv
// Elementary cellular-automaton engine.
// Holds a WIDTH-cell row and applies any 8-bit Wolfram rule, N generations per
// STEP command, driven from a byte-wide command port with a READ response port.
// Optional feature macro: ECA_WRAP_EN (toroidal row); when it is undefined the
// cells beyond both ends of the row read as 0.
module eca_engine #(
  parameter int         WIDTH        = 16,
  parameter logic [7:0] RULE_DEFAULT = 8'd110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic [15:0] gen_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SET_RULE = 2'b01;
  localparam logic [1:0] OP_STEP     = 2'b10;
  localparam logic [1:0] OP_READ     = 2'b11;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cells_q, cells_d;
  logic [7:0]        rule_q, rule_d;
  logic [7:0]        rem_q, rem_d;
  logic [15:0]       gen_q, gen_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;

  logic [WIDTH-1:0]  next_row;
  logic [WIDTH+1:0]  ext;
  logic              bnd_l, bnd_r;
  logic [7:0]        rd_byte;
  logic              accept;

  // Ready is forced low while reset is asserted, even though state already reads IDLE.
  assign cmd_ready = ena & rst_n & (state_q == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;

`ifdef ECA_WRAP_EN
  assign bnd_l = cells_q[0];
  assign bnd_r = cells_q[WIDTH-1];
`else
  assign bnd_l = 1'b0;
  assign bnd_r = 1'b0;
`endif

  // Row padded with its boundary neighbours: ext[i+2]=left, ext[i+1]=self, ext[i]=right.
  assign ext = {bnd_l, cells_q, bnd_r};

  // One generation of the whole row, looked up in the current rule byte.
  always_comb begin
    next_row = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_row[i] = rule_q[{ext[i+2], ext[i+1], ext[i]}];
    end
  end

  // Byte selected by a READ index; indices past the row return zero.
  always_comb begin
    rd_byte = 8'h00;
    for (int j = 0; j < WIDTH / 8; j++) begin
      if (cmd_data == 8'(j)) begin
        rd_byte = cells_q[8*j +: 8];
      end
    end
  end

  // Next-state logic: command decode in IDLE, generation stepping in RUN.
  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    rule_d      = rule_q;
    rem_d       = rem_q;
    gen_d       = gen_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_LOAD: begin
                cells_d = {cells_q[WIDTH-9:0], cmd_data};
                gen_d   = 16'd0;
              end
              OP_SET_RULE: rule_d = cmd_data;
              OP_STEP: begin
                if (cmd_data != 8'd0) begin
                  rem_d   = cmd_data;
                  state_d = S_RUN;
                end
              end
              OP_READ: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd_byte;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          cells_d = next_row;
          gen_d   = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset discards any partial run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cells_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
      rule_q      <= RULE_DEFAULT;
      rem_q       <= 8'd0;
      gen_q       <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      rule_q      <= rule_d;
      rem_q       <= rem_d;
      gen_q       <= gen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign gen_count = gen_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_eca_engine.sv
// Testbench for eca_engine (WIDTH=16): directed scenarios plus randomized
// commands; READ responses are checked from a scoreboard queue by a monitor.
module tb_eca_engine;

  localparam int W = 16;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [15:0] gen_count;

  eca_engine #(.WIDTH(W), .RULE_DEFAULT(8'd110)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .gen_count (gen_count)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  // reference model state
  logic [W-1:0] m_cells;
  logic [7:0]   m_rule;
  int           m_gen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one generation computed cell by cell from the Wolfram rule definition
  function automatic logic [W-1:0] model_gen(input logic [W-1:0] c, input logic [7:0] r);
    logic [W-1:0] n;
    int l, s, rr, idx;
    bit wrap;
`ifdef ECA_WRAP_EN
    wrap = 1'b1;
`else
    wrap = 1'b0;
`endif
    n = '0;
    for (int i = 0; i < W; i++) begin
      l  = (i == W - 1 && !wrap) ? 0 : int'(c[(i + 1) % W]);
      rr = (i == 0 && !wrap) ? 0 : int'(c[(i + W - 1) % W]);
      s  = int'(c[i]);
      idx = l * 4 + s * 2 + rr;
      n[i] = r[idx];
    end
    return n;
  endfunction

  function automatic logic [7:0] model_read(input int k);
    logic [W-1:0] sh;
    if (k >= W / 8) return 8'h00;
    sh = m_cells >> (8 * k);
    return sh[7:0];
  endfunction

  task automatic model_reset();
    m_cells = 16'h0001;
    m_rule  = 8'd110;
    m_gen   = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one command at a negedge once ready; returns just after the accepting edge
  // with cmd_valid still high so the next call can follow back-to-back.
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", t);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    case (op)
      2'b00: begin m_cells = {m_cells[W-9:0], d}; m_gen = 0; end
      2'b01: m_rule = d;
      2'b10: begin
        for (int g = 0; g < int'(d); g++) m_cells = model_gen(m_cells, m_rule);
        m_gen = (m_gen + int'(d) > 65535) ? 65535 : m_gen + int'(d);
      end
      default: ;
    endcase
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic rd(input int k, input logic [7:0] exp);
    exp_q.push_back(exp);
    issue(2'b11, 8'(k));
  endtask

  // STEP and measure how many cycles busy stays high, then check ready and gen_count.
  task automatic step(input logic [7:0] n);
    int cnt;
    cnt = 0;
    issue(2'b10, n);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (busy && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(cnt), 32'(n));
    check("ready_after_run", 32'(cmd_ready), 32'd1);
    check("gen_count", 32'(gen_count), 32'(m_gen));
  endtask

  // scoreboard monitor: every READ response is popped and compared
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid with data 0x%0h, expected no response", rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rsp_data !== mon_exp) begin
          errors++;
          $display("FAIL rsp_data: got 0x%0h, expected 0x%0h", rsp_data, mon_exp);
        end
      end
    end
  end

  initial begin
    int t;
    int eb;
    logic [1:0] op;
    int k;

    rst_n     = 1'b0;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    model_reset();

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    check("rst_gen_count", 32'(gen_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 32'(cmd_ready), 32'd1);

    // 1: rule 110 from reset row
    step(8'd3);
    rd(0, 8'h0D);
    rd(1, 8'h00);
    idle();
    check("t1_gen_count", 32'(gen_count), 32'd3);

    // 2: loads shift in bytes, out-of-range read is zero
    issue(2'b00, 8'h12);
    issue(2'b00, 8'h34);
    rd(0, 8'h34);
    rd(1, 8'h12);
    rd(2, 8'h00);
    rd(255, 8'h00);
    idle();
    check("t2_gen_count", 32'(gen_count), 32'd0);

    // 3: rule 90
    issue(2'b01, 8'h5A);
    issue(2'b00, 8'h01);
    issue(2'b00, 8'h00);
    step(8'd1);
    rd(0, 8'h80);
    rd(1, 8'h02);

    // 4: boundary behaviour
    issue(2'b01, 8'd110);
    issue(2'b00, 8'h80);
    issue(2'b00, 8'h00);
    step(8'd1);
    rd(1, 8'h80);
`ifdef ECA_WRAP_EN
    rd(0, 8'h01);
`else
    rd(0, 8'h00);
`endif

    // 5: ena low freezes a run after its first generation
    issue(2'b00, 8'h00);
    issue(2'b00, 8'h01);
    issue(2'b10, 8'd3);
    eb = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (busy) eb++;
    @(negedge clk);
    if (busy) eb++;
    ena = 1'b0;
    check("t5_gen_after_first", 32'(gen_count), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("t5_busy_frozen", 32'(busy), 32'd1);
      check("t5_gen_frozen", 32'(gen_count), 32'd1);
    end
    check("t5_ready_frozen", 32'(cmd_ready), 32'd0);
    ena = 1'b1;
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      eb++;
      t++;
      @(negedge clk);
    end
    check("t5_busy_ena_cycles", 32'(eb), 32'd3);
    check("t5_gen_count", 32'(gen_count), 32'd3);
    rd(0, 8'h0D);
    rd(1, 8'h00);

    // 6: reset in the middle of a long run
    issue(2'b10, 8'd200);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_busy_midrun", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_gen_rst", 32'(gen_count), 32'd0);
    check("t6_ready_rst", 32'(cmd_ready), 32'd0);
    check("t6_rsp_valid_rst", 32'(rsp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_ready_release", 32'(cmd_ready), 32'd1);
    rd(0, 8'h01);
    rd(1, 8'h00);
    step(8'd1);
    rd(0, 8'h03);

    // randomized commands against the reference model
    for (int it = 0; it < 150; it++) begin
      op = 2'($urandom_range(0, 3));
      case (op)
        2'b00: issue(2'b00, 8'($urandom));
        2'b01: issue(2'b01, 8'($urandom));
        2'b10: step(8'($urandom_range(0, 12)));
        default: begin
          k = $urandom_range(0, 3);
          rd(k, model_read(k));
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle();
    end
    for (int k2 = 0; k2 < 2; k2++) rd(k2, model_read(k2));
    idle();

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rsp_outstanding", 32'(exp_q.size()), 32'd0);
    check("final_gen_count", 32'(gen_count), 32'(m_gen));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
